// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: 2-cycle MULT/MULTU, 32-step restoring DIV/DIVU.
// Optional build macro DIV_ZERO_FAST_EN: a divide by zero completes at once with lo=all ones, hi=dividend.

package ex_muldiv_pkg;
    localparam int DataBus = 32;
    localparam int ALUOp   = 6;

    localparam logic [ALUOp-1:0] ALU_NOP   = 6'h00;
    localparam logic [ALUOp-1:0] ALU_MULT  = 6'h18;
    localparam logic [ALUOp-1:0] ALU_MULTU = 6'h19;
    localparam logic [ALUOp-1:0] ALU_DIV   = 6'h1A;
    localparam logic [ALUOp-1:0] ALU_DIVU  = 6'h1B;
endpackage

module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stall,
    input  logic [ALUOp-1:0]   ex_aluop,
    input  logic [DataBus-1:0] ex_opr1,
    input  logic [DataBus-1:0] ex_opr2,
    output logic [DataBus-1:0] md_hi,
    output logic [DataBus-1:0] md_lo,
    output logic               md_wen,
    output logic               stallreq
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [4:0]         cnt;
    logic [DataBus-1:0] a_mag, b_mag, rem, quo;
    logic               neg_q, neg_r, wen_done;

    logic               is_mul, is_div, is_signed, is_md, s1, s2, div_zero_fast;
    logic [DataBus-1:0] opr1_mag, opr2_mag;
    logic [63:0]        product, prod_fix;
    logic [32:0]        rem_sh, trial;
    logic [DataBus-1:0] rem_nxt, quo_nxt, rem_fix, quo_fix;

    assign is_mul    = (ex_aluop == ALU_MULT) || (ex_aluop == ALU_MULTU);
    assign is_div    = (ex_aluop == ALU_DIV)  || (ex_aluop == ALU_DIVU);
    assign is_signed = (ex_aluop == ALU_MULT) || (ex_aluop == ALU_DIV);
    assign is_md     = is_mul || is_div;
    assign s1        = is_signed && ex_opr1[31];
    assign s2        = is_signed && ex_opr2[31];
    assign opr1_mag  = s1 ? -ex_opr1 : ex_opr1;
    assign opr2_mag  = s2 ? -ex_opr2 : ex_opr2;

`ifdef DIV_ZERO_FAST_EN
    assign div_zero_fast = is_div && (ex_opr2 == '0);
`else
    assign div_zero_fast = 1'b0;
`endif

    // Product is formed from magnitudes; neg_q carries the product sign for multiplies.
    assign product  = {32'b0, a_mag} * {32'b0, b_mag};
    assign prod_fix = neg_q ? -product : product;

    // One restoring step; the shifted remainder needs 33 bits before the compare.
    assign rem_sh  = {rem, quo[31]};
    assign trial   = rem_sh - {1'b0, b_mag};
    assign rem_nxt = trial[32] ? rem_sh[31:0] : trial[31:0];
    assign quo_nxt = {quo[30:0], ~trial[32]};
    assign rem_fix = neg_r ? -rem_nxt : rem_nxt;
    assign quo_fix = neg_q ? -quo_nxt : quo_nxt;

    always_comb begin
        state_nxt = state;
        stallreq  = 1'b0;
        md_wen    = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_md && !flush) begin
                    stallreq = 1'b1;
                    if (div_zero_fast)  state_nxt = S_DONE;
                    else if (is_mul)    state_nxt = S_MUL;
                    else                state_nxt = S_DIV;
                end
            end
            S_MUL: begin
                stallreq  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DIV: begin
                stallreq = 1'b1;
                if (cnt == 5'd31) state_nxt = S_DONE;
            end
            S_DONE: begin
                md_wen = !wen_done;
                if (!stall) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            md_wen    = 1'b0;
        end
        if (rst) begin
            stallreq = 1'b0;
            md_wen   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            wen_done <= 1'b0;
            md_hi    <= '0;
            md_lo    <= '0;
        end else begin
            state    <= state_nxt;
            // Marks DONE cycles after the first so a stalled DONE writes HI/LO only once.
            wen_done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (is_md && !flush) begin
                        a_mag <= opr1_mag;
                        b_mag <= opr2_mag;
                        neg_q <= s1 ^ s2;
                        neg_r <= s1;
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= opr1_mag;
                        if (div_zero_fast) begin
                            md_hi <= ex_opr1;
                            md_lo <= '1;
                        end
                    end
                end
                S_MUL: begin
                    if (!flush) {md_hi, md_lo} <= prod_fix;
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31 && !flush) begin
                        md_hi <= rem_fix;
                        md_lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, stall-request window, results, flush, DONE stall, divide by zero.
`timescale 1ns/1ps
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic              clk = 1'b0;
    logic              rst, flush, stall;
    logic [ALUOp-1:0]  ex_aluop;
    logic [31:0]       ex_opr1, ex_opr2;
    logic [31:0]       md_hi, md_lo;
    logic              md_wen, stallreq;

    int n_cmp = 0;
    int n_bad = 0;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .ex_aluop(ex_aluop), .ex_opr1(ex_opr1), .ex_opr2(ex_opr2),
        .md_hi(md_hi), .md_lo(md_lo), .md_wen(md_wen), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Presents an op in the current IDLE cycle, waits for the write strobe, optionally
    // stalls DONE, then lets ID/EX advance to a NOP.
    task automatic run_op(input string tag, input logic [ALUOp-1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n_stall, input int exp_lat, input bit chk_val,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        int n_sreq;
        bit got;
        k = 0; n_sreq = 0; got = 0;
        ex_aluop = op; ex_opr1 = a; ex_opr2 = b;
        #1;
        while (k < 60 && !got) begin
            if (md_wen) got = 1;
            else begin
                if (stallreq) n_sreq++;
                tick();
                k++;
            end
        end
        chk({tag, " wen_seen"}, 64'(got), 64'd1);
        chk({tag, " latency"}, 64'(k), 64'(exp_lat));
        chk({tag, " stallreq_cycles"}, 64'(n_sreq), 64'(exp_lat));
        chk({tag, " stallreq_done"}, 64'(stallreq), 64'd0);
        if (chk_val) chk({tag, " result"}, {md_hi, md_lo}, {exp_hi, exp_lo});
        if (n_stall > 0) begin
            stall = 1'b1;
            for (int i = 0; i < n_stall; i++) begin
                tick();
                chk({tag, " wen_held_low"}, 64'(md_wen), 64'd0);
                chk({tag, " stallreq_held"}, 64'(stallreq), 64'd0);
                if (chk_val) chk({tag, " result_held"}, {md_hi, md_lo}, {exp_hi, exp_lo});
            end
            stall = 1'b0;
        end
        tick();
        ex_aluop = ALU_NOP;
        #1;
        chk({tag, " idle_wen"}, 64'(md_wen), 64'd0);
        chk({tag, " idle_stallreq"}, 64'(stallreq), 64'd0);
    endtask

    initial begin
        int wen_cnt;
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        ex_aluop = ALU_NOP; ex_opr1 = '0; ex_opr2 = '0;
        tick(); tick();
        chk("reset hi/lo", {md_hi, md_lo}, 64'd0);
        chk("reset wen", 64'(md_wen), 64'd0);
        chk("reset stallreq", 64'(stallreq), 64'd0);
        rst = 1'b0;
        tick();

        run_op("multu_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", ALU_MULT, 32'hFFFF_FFFD, 32'd7, 0, 2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_minsq", ALU_MULT, 32'h8000_0000, 32'h8000_0000, 0, 2, 1, 32'h4000_0000, 32'h0);
        run_op("div_neg7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 33, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 3, 33, 1, 32'd2, 32'd14);
        run_op("div_7_neg2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 0, 33, 1, 32'd1, 32'hFFFF_FFFD);
        run_op("div_min_neg1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 1, 32'd0, 32'h8000_0000);
        run_op("mult_stall", ALU_MULT, 32'd6, 32'hFFFF_FFFB, 2, 2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFE2);

        // Flush at divide step 10: result from mult_stall must survive.
        ex_aluop = ALU_DIVU; ex_opr1 = 32'd1000; ex_opr2 = 32'd3;
        for (int i = 0; i < 11; i++) tick();
        chk("flush pre stallreq", 64'(stallreq), 64'd1);
        flush = 1'b1; ex_aluop = ALU_NOP;
        #1;
        chk("flush wen", 64'(md_wen), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush stallreq_drop", 64'(stallreq), 64'd0);
        chk("flush hi/lo kept", {md_hi, md_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFE2});
        wen_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (md_wen || stallreq) wen_cnt++;
        end
        chk("flush no activity", 64'(wen_cnt), 64'd0);

`ifdef DIV_ZERO_FAST_EN
        run_op("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 0, 1, 1, 32'd5, 32'hFFFF_FFFF);
        run_op("div_neg5_0", ALU_DIV, 32'hFFFF_FFFB, 32'd0, 0, 1, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
`else
        run_op("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 0, 33, 0, 32'd0, 32'd0);
`endif
        run_op("multu_after", ALU_MULTU, 32'd12345, 32'd1000, 0, 2, 1, 32'd0, 32'd12345000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
